// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline control logic (hazard unit, forwarding unit).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  localparam int          REG_W_DEF = 5;
  localparam int unsigned REG_X0    = 0;

  // Width-agnostic: callers do the register compares, so any REG_W can share this.
  function automatic logic load_use(input logic memread,
                                    input logic rd_nonzero,
                                    input logic rs1_used,
                                    input logic rs1_match,
                                    input logic rs2_used,
                                    input logic rs2_match);
    return memread & rd_nonzero & ((rs1_used & rs1_match) | (rs2_used & rs2_match));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, memory freeze,
// branch flush, memory-stall watchdog and saturating performance counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam bit WD_EN  = (MEM_TIMEOUT != 0);
  // Wide enough to hold MEM_TIMEOUT, so the compare is always reached before any wrap.
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu;
  logic              freeze;

  assign lu = load_use(idex_memread_i,
                       idex_rd_i != REG_W'(REG_X0),
                       id_rs1_used_i, idex_rd_i == id_rs1_i,
                       id_rs2_used_i, idex_rd_i == id_rs2_i);

  assign freeze        = mem_stall_i | (state == TIMEOUT);
  assign timeout_err_o = (state == TIMEOUT);

  // Priority freeze > load-use > branch; a branch resolved alongside a load-use used stale operands.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    if (freeze) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      freeze_o     = 1'b1;
    end else if (lu) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Watchdog: wait_cnt holds the number of consecutive stalled cycles seen so far.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall_i) begin
            if (MEM_TIMEOUT == 1) begin
              state <= TIMEOUT;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= WAIT_W'(1);
            end
          end
        end
        MEM_WAIT: begin
          if (!mem_stall_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (WD_EN && (wait_cnt == WAIT_LAST)) begin
            state <= TIMEOUT;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        TIMEOUT: state <= TIMEOUT;
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (freeze_o | idex_bubble_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ifid_flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;
  localparam int MT    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, idex_rd;
  logic             id_rs1_used, id_rs2_used, idex_memread, branch_taken, mem_stall;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, freeze, timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Model: consecutive stall length, sticky timeout flag, plain integer counters.
  int m_stall_run = 0;
  bit m_timed_out = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_rs1_used_i  (id_rs1_used),
    .id_rs2_used_i  (id_rs2_used),
    .idex_memread_i (idex_memread),
    .idex_rd_i      (idex_rd),
    .branch_taken_i (branch_taken),
    .mem_stall_i    (mem_stall),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .freeze_o       (freeze),
    .timeout_err_o  (timeout_err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  // Drive one cycle of inputs, check all outputs mid-cycle, then advance the model over the edge.
  task automatic apply(input logic r, input logic mr, input logic [REG_W-1:0] rd,
                       input logic [REG_W-1:0] rs1, input logic u1,
                       input logic [REG_W-1:0] rs2, input logic u2,
                       input logic br, input logic ms);
    bit e_lu, e_freeze, e_bubble, e_flush, e_adv;
    rst = r; idex_memread = mr; idex_rd = rd;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    branch_taken = br; mem_stall = ms;
    @(negedge clk);
    e_lu     = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    e_freeze = ms || m_timed_out;
    e_bubble = !e_freeze && e_lu;
    e_flush  = !e_freeze && !e_lu && br;
    e_adv    = !e_freeze && !e_lu;
    check("pc_write",    32'(pc_write),    32'(e_adv));
    check("ifid_write",  32'(ifid_write),  32'(e_adv));
    check("ifid_flush",  32'(ifid_flush),  32'(e_flush));
    check("idex_bubble", 32'(idex_bubble), 32'(e_bubble));
    check("freeze",      32'(freeze),      32'(e_freeze));
    check("timeout_err", 32'(timeout_err), 32'(m_timed_out));
    check("stall_cnt",   32'(stall_cnt),   32'(m_stall_cnt));
    check("flush_cnt",   32'(flush_cnt),   32'(m_flush_cnt));
    if (r) begin
      m_stall_run = 0; m_timed_out = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (!m_timed_out) begin
        if (ms) begin
          m_stall_run++;
          if (MT != 0 && m_stall_run == MT) m_timed_out = 1;
        end else begin
          m_stall_run = 0;
        end
      end
      if ((e_freeze || e_bubble) && m_stall_cnt < CMAX) m_stall_cnt++;
      if (e_flush && m_flush_cnt < CMAX) m_flush_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int burst = 0;
    logic r, ms, mr, u1, u2, br;
    logic [REG_W-1:0] rd, rs1, rs2;

    // Raw reset before the model takes over; outputs are undefined until it lands.
    rst = 1; idex_memread = 0; idex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0; branch_taken = 0; mem_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset state, then a single load-use bubble.
    idle();
    apply(0, 1, 5, 5, 1, 0, 0, 0, 0);
    idle();

    // rd = x0 and unused rs2 never stall.
    apply(0, 1, 0, 0, 1, 0, 0, 0, 0);
    apply(0, 1, 7, 0, 0, 7, 0, 0, 0);
    idle();

    // Branch alongside load-use is dropped; branch alone flushes.
    apply(0, 1, 5, 5, 1, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // Memory stall over a pending load-use, then one bubble on release.
    repeat (3) apply(0, 1, 6, 0, 0, 6, 1, 0, 1);
    apply(0, 1, 6, 0, 0, 6, 1, 0, 0);
    idle();

    // Watchdog trips after MT stalled cycles and stays frozen until reset.
    repeat (6) apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Flush counter saturation.
    repeat (9) apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // Exactly MT-1 stalls must not trip the watchdog.
    repeat (MT - 1) apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with stall bursts and occasional resets.
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 24) == 0);
      if (burst > 0) begin
        ms = 1; burst--;
      end else if ($urandom_range(0, 9) == 0) begin
        ms = 1; burst = $urandom_range(0, 5);
      end else begin
        ms = 0;
      end
      mr  = $urandom_range(0, 1);
      rd  = REG_W'($urandom_range(0, 3));
      rs1 = REG_W'($urandom_range(0, 3));
      rs2 = REG_W'($urandom_range(0, 3));
      u1  = $urandom_range(0, 1);
      u2  = $urandom_range(0, 1);
      br  = ($urandom_range(0, 3) == 0);
      apply(r, mr, rd, rs1, u1, rs2, u2, br, ms);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RISC-V pipeline.
- Detects load-use hazards between the ID stage and the ID/EX register.
- Freezes the whole pipeline while data memory reports a stall.
- Flushes IF/ID on a branch taken in ID.
- Runs a memory-stall watchdog and saturating stall/flush performance counters.
- Sits beside the pipeline registers; its outputs drive PC enable, IF/ID enable/flush, the ID/EX bubble mux and the EX/MEM and MEM/WB hold enables.

Parameters:
- REG_W, 5: register address width.
- CNT_W, 32: performance counter width.
- MEM_TIMEOUT, 64: consecutive mem-stall cycles before the sticky error is raised; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- id_rs1_i  in  REG_W  rs1 of the instruction in ID.
- id_rs2_i  in  REG_W  rs2 of the instruction in ID.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- idex_memread_i  in  1  MemRead currently held in ID/EX.
- idex_rd_i  in  REG_W  rd currently held in ID/EX.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- mem_stall_i  in  1  data memory not ready; pipeline must hold.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID clears to NOP on the next edge.
- idex_bubble_o  out  1  zero the control inputs of ID/EX this edge.
- freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- timeout_err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  cycles with any stall (load-use or freeze).
- flush_cnt_o  out  CNT_W  branch flushes issued.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: state=RUN, wait counter=0, timeout_err_o=0, stall_cnt_o=0, flush_cnt_o=0.
- All control outputs are combinational from the inputs and the current state (zero latency). Counters and state update on posedge clk_i.
- Load-use hazard: lu = idex_memread_i & (idex_rd_i!=0) & ((id_rs1_used_i & idex_rd_i==id_rs1_i) | (id_rs2_used_i & idex_rd_i==id_rs2_i)).
- Priority: freeze > load-use > branch.
- Freeze: asserted when mem_stall_i=1 or state=TIMEOUT.
  - Outputs: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, freeze_o=1.
  - lu and branch_taken_i are ignored; they are re-evaluated after the freeze.
- Load-use, no freeze: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0.
  - A simultaneous branch_taken_i is ignored because its operands are stale.
  - Exactly one bubble per hazard; the load moves to MEM next cycle, so lu self-clears.
- Branch, no freeze and no lu: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
- Idle: pc_write_o=1, ifid_write_o=1, every other control output 0.
- FSM states: RUN, MEM_WAIT, TIMEOUT.
  - RUN -> MEM_WAIT when mem_stall_i=1; wait counter loads 1.
  - MEM_WAIT: counter increments while mem_stall_i=1; returns to RUN with counter=0 on the first cycle mem_stall_i=0.
  - MEM_WAIT -> TIMEOUT when MEM_TIMEOUT!=0, mem_stall_i=1 and counter==MEM_TIMEOUT-1.
  - TIMEOUT: timeout_err_o=1 and freeze_o=1 permanently, regardless of mem_stall_i; exits only via rst_i.
  - With MEM_TIMEOUT=0, TIMEOUT is unreachable.
- Wait counter width is clog2(MEM_TIMEOUT+1), minimum 1 bit. It must not wrap before the compare.
- stall_cnt_o increments in any cycle with freeze_o | idex_bubble_o. flush_cnt_o increments in any cycle with ifid_flush_o. Both saturate at all-ones and never wrap.
- Reset mid-stall: rst_i wins on that edge. All state and counters clear; outputs return to idle values in the following cycle.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, TIMEOUT);
  - REG_W default and the x0 constant;
  - a function for the load-use compare, shareable with the forwarding unit.
- Sub-module sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice for the performance counters.

Test Plan:
- Load-use: idex_memread_i=1, idex_rd_i=5, id_rs1_i=5, id_rs1_used_i=1 for one cycle -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 that cycle; stall_cnt_o=1 next cycle.
- rd=x0 or unused operand: idex_rd_i=0 with matching rs1; then idex_rd_i=7, id_rs2_i=7, id_rs2_used_i=0 -> no stall in either case; stall_cnt_o stays 0.
- Branch vs load-use: branch_taken_i=1 with lu=1 -> no flush, bubble=1; next cycle branch_taken_i=1 alone -> ifid_flush_o=1, flush_cnt_o=1.
- Memory stall: mem_stall_i high 3 cycles with lu=1 throughout -> freeze_o=1 for 3 cycles, idex_bubble_o=0; on release, 1 bubble; stall_cnt_o=4.
- Watchdog: MEM_TIMEOUT=4, mem_stall_i held high -> timeout_err_o=1 from cycle 5; drop mem_stall_i -> freeze_o stays 1; rst_i=1 for one cycle -> all outputs idle, counters 0.
- Saturation: CNT_W=3, 9 consecutive flush cycles -> flush_cnt_o reads 7 and holds.
